// File: rtl/fir_filter_pipe_if.sv
// Streaming sample interface for fir_filter_pipe: input samples (x) and filtered
// output samples (y), each with valid/ready handshake and an even-parity bit.
interface fir_filter_pipe_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] x_data;
    logic                  x_valid;
    logic                  x_parity;
    logic                  x_ready;
    logic [DATA_WIDTH-1:0] y_data;
    logic                  y_valid;
    logic                  y_parity;
    logic                  y_ready;

    modport master (
        output x_data, x_valid, x_parity, y_ready,
        input  x_ready, y_data, y_valid, y_parity
    );

    modport slave (
        input  x_data, x_valid, x_parity, y_ready,
        output x_ready, y_data, y_valid, y_parity
    );
endinterface

// File: rtl/fir_filter_pipe.sv
// TAPS-tap unsigned FIR with programmable coefficients, two-stage pipeline
// (products, then sum), valid/ready backpressure and parity poison tracking.
module fir_filter_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int TAPS       = 4,
    parameter int COEF_WIDTH = 8,
    parameter int RESET_C0   = 4,
    localparam int IDX_WIDTH = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fir_filter_pipe_if.slave      bus,
    input  logic                  coef_wr,
    input  logic [IDX_WIDTH-1:0]  coef_idx,
    input  logic [COEF_WIDTH-1:0] coef_data,
    input  logic                  flush,
    output logic [7:0]            err_count
);

    logic [DATA_WIDTH-1:0] d         [TAPS];
    logic                  perr      [TAPS];
    logic [COEF_WIDTH-1:0] coef      [TAPS];
    logic [DATA_WIDTH-1:0] prod      [TAPS];
    logic [DATA_WIDTH-1:0] prod_next [TAPS];

    logic                  stall;
    logic                  accept;
    logic                  x_bad;
    logic                  s1_valid;
    logic                  s1_poison;
    logic                  s1_poison_next;
    logic [DATA_WIDTH-1:0] sum_next;
    logic [DATA_WIDTH-1:0] y_data_q;
    logic                  y_valid_q;
    logic                  y_parity_q;

    assign stall  = y_valid_q & ~bus.y_ready;
    assign accept = bus.x_valid & ~stall & ~flush;
    assign x_bad  = bus.x_parity ^ (^bus.x_data);

    assign bus.x_ready  = ~stall;
    assign bus.y_data   = y_data_q;
    assign bus.y_valid  = y_valid_q;
    assign bus.y_parity = y_parity_q;

    // Only the low DATA_WIDTH bits of each product matter, since the output
    // sum wraps modulo 2^DATA_WIDTH.
    always_comb begin
        prod_next[0]   = DATA_WIDTH'(coef[0]) * bus.x_data;
        s1_poison_next = x_bad;
        for (int i = 1; i < TAPS; i++) begin
            prod_next[i]   = DATA_WIDTH'(coef[i]) * d[i-1];
            s1_poison_next = s1_poison_next | perr[i-1];
        end
    end

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum_next = sum_next + prod[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                d[i]    <= '0;
                perr[i] <= 1'b0;
                prod[i] <= '0;
            end
            s1_valid   <= 1'b0;
            s1_poison  <= 1'b0;
            y_data_q   <= '0;
            y_valid_q  <= 1'b0;
            y_parity_q <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < TAPS; i++) begin
                d[i]    <= '0;
                perr[i] <= 1'b0;
            end
            s1_valid  <= 1'b0;
            y_valid_q <= 1'b0;
        end else if (!stall) begin
            if (accept) begin
                d[0]    <= bus.x_data;
                perr[0] <= x_bad;
                for (int i = 1; i < TAPS; i++) begin
                    d[i]    <= d[i-1];
                    perr[i] <= perr[i-1];
                end
                for (int i = 0; i < TAPS; i++) begin
                    prod[i] <= prod_next[i];
                end
                s1_poison <= s1_poison_next;
            end
            s1_valid   <= accept;
            y_data_q   <= sum_next;
            y_valid_q  <= s1_valid;
            y_parity_q <= (^sum_next) ^ s1_poison;
        end
    end

    // Coefficient writes ignore stall; an index with no matching tap is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= (i == 0) ? COEF_WIDTH'(RESET_C0) : '0;
            end
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                if (coef_wr && (coef_idx == IDX_WIDTH'(i))) begin
                    coef[i] <= coef_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= '0;
        end else if (accept && x_bad && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: doc/fir_filter_pipe.md
# fir_filter_pipe

Parametrised successor to the fixed-gain filter block: a TAPS-tap unsigned FIR filter with runtime-programmable coefficients, valid/ready backpressure on both sides, and even-parity checking with poison propagation. It sits in the same streaming datapath position as the current filter and keeps its x/y port set. It adds `x_ready`/`y_ready` and a coefficient-write port. Its reset coefficients reproduce the current behaviour, y = 4·x after two clock edges.

## Interface
- DATA_WIDTH, 16, sample width, for input and output.
- TAPS, 4, number of taps / delay-line depth (≥1).
- COEF_WIDTH, 8, unsigned coefficient width.
- RESET_C0, 4, reset value of coefficient 0; all other coefficients reset to 0.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- x_data  in  DATA_WIDTH  input sample.
- x_valid  in  1  input sample valid.
- x_parity  in  1  even parity of x_data: expected value = XOR of all x_data bits.
- x_ready  out  1  filter can accept a sample.
- y_data  out  DATA_WIDTH  filtered sample.
- y_valid  out  1  output valid.
- y_parity  out  1  even parity of y_data, inverted when the sample is poisoned.
- y_ready  in  1  downstream accepts the output.
- coef_wr  in  1  coefficient write strobe.
- coef_idx  in  clog2(TAPS), min 1  coefficient index.
- coef_data  in  COEF_WIDTH  coefficient value.
- flush  in  1  synchronous clear of the delay line and pipeline.
- err_count  out  8  saturating count of input parity errors.

## Operation
- State:
  - delay line d[0..TAPS-1] of DATA_WIDTH, each entry with a perr bit.
  - coefficient registers c[0..TAPS-1].
  - stage-1 register: TAPS products, s1_valid, s1_poison.
  - stage-2 output registers: y_data, y_valid, y_parity.
  - err_count.
- Reset (rst=0, asynchronous, immediate):
  - d, perr bits, products, y_data, y_valid, y_parity, s1_valid and err_count all go to 0.
  - c[0]=RESET_C0; other coefficients go to 0.
  - x_ready=1 once out of reset, because y_valid=0.
- Stall:
  - stall = y_valid & ~y_ready.
  - x_ready = ~stall, combinational.
  - While stall is high, all pipeline registers and the delay line hold.
- Accept: x_valid & x_ready at a rising edge.
  - Delay line shifts: d[0]←x_data, d[i]←d[i-1].
  - perr[0] ← x_parity ≠ XOR(x_data).
  - Stage 1 registers p[i] = c[i]·w[i], where w[0]=x_data and w[i]=d[i-1] (the pre-shift values).
  - s1_poison = OR of the new perr window.
  - s1_valid ← 1.
- No accept and no stall: s1_valid←0.
- Stage 2, when not stalled:
  - y_data ← (Σ p[i]) mod 2^DATA_WIDTH (unsigned, wrap-around, no saturation).
  - y_valid ← s1_valid.
  - y_parity ← XOR(y_data_next) ^ s1_poison.
- Poison: one bad input poisons every output whose window contains it, i.e. the next TAPS accepted samples' outputs, or until flush.
- err_count: increments on each accepted sample with a parity mismatch and saturates at 255. It is not cleared by flush.
- Coefficient writes:
  - coef_wr writes c[coef_idx] at the edge, regardless of stall.
  - coef_idx ≥ TAPS is ignored.
  - A write in the same cycle as an accept: that sample uses the old coefficient; the next sample uses the new one.
- flush, at the edge:
  - Clears d, perr, s1_valid and y_valid. Coefficients are kept.
  - flush together with x_valid: the sample is dropped.
  - flush has priority over stall.

## Timing
- Latency: a sample accepted at edge k appears on y_data/y_valid after edge k+1 (two edges, accept included).
- Throughput: one sample per cycle while y_ready=1.
- Stall:
  - y_data, y_valid and y_parity are held stable while y_valid=1 and y_ready=0.
  - No sample is lost or duplicated.
  - A held output and a sample in stage 1 both survive the stall.
- Mid-operation reset: outputs drop to 0 asynchronously. The first accept after rst rises again uses the reset coefficients and a zeroed delay line.

## Test plan
- Reset defaults: reset, release, x_data=3, x_parity=0, x_valid=1.
  - Before the first edge: y_data=0, y_valid=0, y_parity=0.
  - After two edges: y_data=12, y_valid=1, y_parity=0.
- Moving sum:
  - Write c=[1,1,1,1], then stream 1,2,3,4,5 with y_ready=1.
  - Outputs are 1,3,6,10,14 on consecutive cycles, with correct parity.
- Backpressure:
  - Stream 1..6 with c=[1,1,1,1], holding y_ready=0 for 3 cycles after the first output.
  - x_ready=0 during the hold and y_data is stable at 1.
  - After release the output sequence is 1,3,6,10,14,18 with no gaps or repeats.
- Parity poison: with c=[1,0,0,0], send 5 with x_parity=1 (wrong), then 6, 7, 8, 9 with correct parity.
  - err_count=1.
  - y_parity is inverted on outputs 5, 6, 7 and 8 (TAPS=4), and correct on output 9.
- Wrap and coefficient timing:
  - c0=4, x=0x8001 gives y=0x0004.
  - coef_wr c0=2 in the same cycle as accepting x=10 gives y=40; the next x=10 gives y=20.
- Flush and mid-operation reset:
  - c=[1,1,1,1], stream 5,5, then flush, then 1: output is 1.
  - Asserting rst low mid-stream zeros y_data, y_valid and err_count without waiting for a clock edge.
